// File: rtl/gate_bist_pkg.sv
// Shared definitions for the 2-input gate BIST controller: FSM state codes,
// stimulus vector geometry and the reference truth table of the gate under test.
// Imported by gate_bist_vecgen and gate_bist_ctrl.
package gate_bist_pkg;

    localparam int VEC_W   = 2;
    localparam int NUM_VEC = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Reference model of the andgate cell.
    function automatic logic and_expected(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/gate_bist_vecgen.sv
// Stimulus vector generator: walks vectors 00..11, repeated SWEEPS times.
// Latency: clear/step take effect on the next rising edge.
// Backpressure: none; the controller issues step only once per SAMPLE state.
// Ports: clk, rst (async, active-high), clear_i (restart at vec 0 / sweep 0),
//        step_i (advance one vector), vec_o (current vector), last_o (final
//        vector of the final sweep).
module gate_bist_vecgen
    import gate_bist_pkg::*;
#(
    parameter int SWEEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             step_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             last_o
);

    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VEC - 1);
    localparam logic [3:0]       LAST_SWEEP = 4'(SWEEPS - 1);

    logic [VEC_W-1:0] vec_q;
    logic [3:0]       sweep_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q   <= '0;
            sweep_q <= '0;
        end else if (clear_i) begin
            vec_q   <= '0;
            sweep_q <= '0;
        end else if (step_i) begin
            // The controller never steps past the last vector, so the sweep
            // counter cannot overrun.
            if (vec_q == LAST_VEC) begin
                vec_q   <= '0;
                sweep_q <= sweep_q + 4'd1;
            end else begin
                vec_q   <= vec_q + 1'b1;
            end
        end
    end

    assign vec_o  = vec_q;
    assign last_o = (vec_q == LAST_VEC) && (sweep_q == LAST_SWEEP);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a 2-input AND cell: drive each vector, settle, sample, compare.
// Latency: start at edge k -> done at edge k + 4*SWEEPS*(SETTLE_CYCLES+2).
// Backpressure: start is ignored while busy; start held high restarts from DONE.
// Ports: clk, rst (async, active-high), start, gate_a/gate_b (registered stimulus),
//        gate_out (cell output, synchronous to clk), busy, done, pass.
// Optional error log (macro GATE_BIST_ERRLOG_EN): err_cnt, first_fail_vec, first_fail_vld.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SWEEPS        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_out,
    output logic             busy,
    output logic             done,
`ifdef GATE_BIST_ERRLOG_EN
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_vld,
`endif
    output logic             pass
);

    logic [2:0]       state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [1:0]       gate_q, gate_d;      // {a,b}
    logic             fail_q, fail_d;
    logic             vg_clear, vg_step;
    logic [VEC_W-1:0] vec;
    logic             vec_last;
    logic             mismatch;

`ifdef GATE_BIST_ERRLOG_EN
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       ffv_q, ffv_d;
    logic             ffvld_q, ffvld_d;
`endif

    gate_bist_vecgen #(
        .SWEEPS (SWEEPS)
    ) u_vecgen (
        .clk     (clk),
        .rst     (rst),
        .clear_i (vg_clear),
        .step_i  (vg_step),
        .vec_o   (vec),
        .last_o  (vec_last)
    );

    assign mismatch = (gate_out != and_expected(gate_q[1], gate_q[0]));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        gate_d   = gate_q;
        fail_d   = fail_q;
        vg_clear = 1'b0;
        vg_step  = 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffvld_d  = ffvld_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // The stimulus registers take vector 00 on the same edge
                    // that enters DRIVE.
                    state_d  = ST_DRIVE;
                    gate_d   = 2'b00;
                    fail_d   = 1'b0;
                    vg_clear = 1'b1;
`ifdef GATE_BIST_ERRLOG_EN
                    err_d    = '0;
                    ffv_d    = 2'b00;
                    ffvld_d  = 1'b0;
`endif
                end
            end
            ST_DRIVE: begin
                settle_d = 8'(SETTLE_CYCLES);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_d = settle_q - 8'd1;
                if (settle_q == 8'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_d = 1'b1;
`ifdef GATE_BIST_ERRLOG_EN
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!ffvld_q) begin
                        ffv_d   = gate_q;
                        ffvld_d = 1'b1;
                    end
`endif
                end
                if (vec_last) begin
                    state_d = ST_DONE;
                    gate_d  = 2'b00;
                end else begin
                    // Next vector wraps 11 -> 00 when a new sweep begins.
                    state_d = ST_DRIVE;
                    vg_step = 1'b1;
                    gate_d  = vec + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gate_d  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            gate_q   <= 2'b00;
            fail_q   <= 1'b0;
`ifdef GATE_BIST_ERRLOG_EN
            err_q    <= '0;
            ffv_q    <= 2'b00;
            ffvld_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            gate_q   <= gate_d;
            fail_q   <= fail_d;
`ifdef GATE_BIST_ERRLOG_EN
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffvld_q  <= ffvld_d;
`endif
        end
    end

    assign gate_a = gate_q[1];
    assign gate_b = gate_q[0];
    assign busy   = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done   = (state_q == ST_DONE);
    assign pass   = (state_q == ST_DONE) && !fail_q;

`ifdef GATE_BIST_ERRLOG_EN
    assign err_cnt        = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_vld = ffvld_q;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl with three instances:
// u0 (SETTLE=4, SWEEPS=1), u1 (SWEEPS=2), u2 (SWEEPS=2, ERR_W=2).
// Each instance drives a selectable gate model: 0=AND, 1=OR, 2=stuck-at-1.
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1, start2;
    logic [1:0] mode0, mode1, mode2;
    logic a0, b0, g0, busy0, done0, pass0;
    logic a1, b1, g1, busy1, done1, pass1;
    logic a2, b2, g2, busy2, done2, pass2;
`ifdef GATE_BIST_ERRLOG_EN
    logic [3:0] ec0, ec1;
    logic [1:0] ec2;
    logic [1:0] ffv0, ffv1, ffv2;
    logic       ffl0, ffl1, ffl2;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic gate_model(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return a & b;
            2'd1:    return a | b;
            default: return 1'b1;
        endcase
    endfunction

    assign g0 = gate_model(mode0, a0, b0);
    assign g1 = gate_model(mode1, a1, b1);
    assign g2 = gate_model(mode2, a2, b2);

    gate_bist_ctrl #(.SETTLE_CYCLES(4), .SWEEPS(1), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .gate_a(a0), .gate_b(b0),
        .gate_out(g0), .busy(busy0), .done(done0),
`ifdef GATE_BIST_ERRLOG_EN
        .err_cnt(ec0), .first_fail_vec(ffv0), .first_fail_vld(ffl0),
`endif
        .pass(pass0));

    gate_bist_ctrl #(.SETTLE_CYCLES(4), .SWEEPS(2), .ERR_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .gate_a(a1), .gate_b(b1),
        .gate_out(g1), .busy(busy1), .done(done1),
`ifdef GATE_BIST_ERRLOG_EN
        .err_cnt(ec1), .first_fail_vec(ffv1), .first_fail_vld(ffl1),
`endif
        .pass(pass1));

    gate_bist_ctrl #(.SETTLE_CYCLES(4), .SWEEPS(2), .ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .gate_a(a2), .gate_b(b2),
        .gate_out(g2), .busy(busy2), .done(done2),
`ifdef GATE_BIST_ERRLOG_EN
        .err_cnt(ec2), .first_fail_vec(ffv2), .first_fail_vld(ffl2),
`endif
        .pass(pass2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0 = 2'd0; mode1 = 2'd2; mode2 = 2'd2;
        #1;
        chk("rst_gate_ab", {6'd0, a0, b0}, 8'h0);
        chk("rst_busy", {7'd0, busy0}, 8'h0);
        chk("rst_done", {7'd0, done0}, 8'h0);
        chk("rst_pass", {7'd0, pass0}, 8'h0);
        tick; tick;
        rst = 1'b0;
        tick;

        // Run 1: correct AND gate, start pulsed at edge 0.
        start0 = 1'b1;
        tick;                                   // edge 0
        start0 = 1'b0;
        chk("r1_busy_e0", {7'd0, busy0}, 8'h1);
        chk("r1_gate_e0", {6'd0, a0, b0}, 8'h0);
        repeat (23) tick;                       // edge 23
        chk("r1_done_e23", {7'd0, done0}, 8'h0);
        tick;                                   // edge 24
        chk("r1_done_e24", {7'd0, done0}, 8'h1);
        chk("r1_busy_e24", {7'd0, busy0}, 8'h0);
        chk("r1_pass", {7'd0, pass0}, 8'h1);
        chk("r1_gate_idle", {6'd0, a0, b0}, 8'h0);
`ifdef GATE_BIST_ERRLOG_EN
        chk("r1_err_cnt", {4'd0, ec0}, 8'h0);
        chk("r1_ffvld", {7'd0, ffl0}, 8'h0);
`endif

        // Run 2: restart from DONE, extra start pulses at edges 5 and 10,
        // per-cycle check of the stimulus sequence.
        start0 = 1'b1;
        tick;                                   // edge 0
        start0 = 1'b0;
        chk("r2_done_drop", {7'd0, done0}, 8'h0);
        chk("r2_busy_e0", {7'd0, busy0}, 8'h1);
        for (int n = 1; n <= 24; n++) begin
            start0 = (n == 5) || (n == 10);
            tick;                               // edge n
            start0 = 1'b0;
            chk("r2_gate_ab", {6'd0, a0, b0}, (n < 24) ? 8'(n / 6) : 8'h0);
            chk("r2_busy", {7'd0, busy0}, (n < 24) ? 8'h1 : 8'h0);
            chk("r2_done", {7'd0, done0}, (n == 24) ? 8'h1 : 8'h0);
        end
        chk("r2_pass", {7'd0, pass0}, 8'h1);

        // Run 3: OR gate in place of AND -> mismatches on 01 and 10.
        mode0 = 2'd1;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        repeat (24) tick;
        chk("r3_done", {7'd0, done0}, 8'h1);
        chk("r3_pass", {7'd0, pass0}, 8'h0);
`ifdef GATE_BIST_ERRLOG_EN
        chk("r3_err_cnt", {4'd0, ec0}, 8'h2);
        chk("r3_ffv", {6'd0, ffv0}, 8'h1);
        chk("r3_ffvld", {7'd0, ffl0}, 8'h1);
`endif

        // Run 4: reset during SETTLE of vector 10, then a clean run.
        mode0 = 2'd0;
        start0 = 1'b1;
        tick;                                   // edge 0
        start0 = 1'b0;
        repeat (14) tick;                       // edge 14: SETTLE of vector 10
        chk("r4_gate_pre", {6'd0, a0, b0}, 8'h2);
        rst = 1'b1;
        #1;
        chk("r4_rst_gate", {6'd0, a0, b0}, 8'h0);
        chk("r4_rst_busy", {7'd0, busy0}, 8'h0);
        chk("r4_rst_done", {7'd0, done0}, 8'h0);
        chk("r4_rst_pass", {7'd0, pass0}, 8'h0);
`ifdef GATE_BIST_ERRLOG_EN
        chk("r4_rst_err", {4'd0, ec0}, 8'h0);
`endif
        tick;
        rst = 1'b0;
        tick;
        start0 = 1'b1;
        tick;                                   // edge 0
        start0 = 1'b0;
        repeat (23) tick;
        chk("r4_done_e23", {7'd0, done0}, 8'h0);
        tick;
        chk("r4_done_e24", {7'd0, done0}, 8'h1);
        chk("r4_pass", {7'd0, pass0}, 8'h1);

        // Run 5: stuck-at-1, two sweeps -> 3 mismatches per sweep.
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        repeat (47) tick;
        chk("r5_done_e47", {7'd0, done1}, 8'h0);
        tick;
        chk("r5_done_e48", {7'd0, done1}, 8'h1);
        chk("r5_pass", {7'd0, pass1}, 8'h0);
`ifdef GATE_BIST_ERRLOG_EN
        chk("r5_err_cnt", {4'd0, ec1}, 8'h6);
        chk("r5_ffv", {6'd0, ffv1}, 8'h0);
        chk("r5_ffvld", {7'd0, ffl1}, 8'h1);
`endif

        // Run 6: 2-bit error counter saturates, then restart from DONE.
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        repeat (48) tick;
        chk("r6_done", {7'd0, done2}, 8'h1);
        chk("r6_pass", {7'd0, pass2}, 8'h0);
`ifdef GATE_BIST_ERRLOG_EN
        chk("r6_err_sat", {6'd0, ec2}, 8'h3);
`endif
        mode2 = 2'd0;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        chk("r6_done_drop", {7'd0, done2}, 8'h0);
        chk("r6_busy", {7'd0, busy2}, 8'h1);
`ifdef GATE_BIST_ERRLOG_EN
        chk("r6_err_clr", {6'd0, ec2}, 8'h0);
`endif
        repeat (48) tick;
        chk("r6_done2", {7'd0, done2}, 8'h1);
        chk("r6_pass2", {7'd0, pass2}, 8'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Built-in self-test sequencer for a 2-input combinational gate (the team's andgate cell).
- Drives every input combination into the gate and waits a programmable settle time.
- Samples the gate output and compares it against the AND truth table.
- Reports pass/fail.
- Sits between the gate instance and board-level status logic (LEDs/UART); replaces free-running bench stimulus with a synthesizable controller.

Parameters:
- SETTLE_CYCLES, 4, cycles between driving a vector and sampling the output (legal range 1..255).
- SWEEPS, 1, number of full 4-vector sweeps per run (1..15).
- ERR_W, 4, width of the mismatch counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled on rising edge.
- gate_a  out  1  registered stimulus to gate input a.
- gate_b  out  1  registered stimulus to gate input b.
- gate_out  in  1  gate output under test.
- busy  out  1  high while a run is in progress.
- done  out  1  level, high in DONE until the next start.
- pass  out  1  valid when done=1; 1 means zero mismatches.
- err_cnt  out  ERR_W  saturating mismatch count (GATE_BIST_ERRLOG_EN only).
- first_fail_vec  out  2  {a,b} of first mismatching vector (GATE_BIST_ERRLOG_EN only).
- first_fail_vld  out  1  first_fail_vec is valid (GATE_BIST_ERRLOG_EN only).

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0, including gate_a, gate_b, busy, done, pass, err_cnt, first_fail_*. Internal vector, sweep and settle counters are 0.
- Vector order is 00, 01, 10, 11, with gate_a=vec[1] and gate_b=vec[0]. Expected output = gate_a & gate_b.
- States:
  - IDLE: outputs idle. start=1 → DRIVE with vec=0, sweep=0, and error state cleared.
  - DRIVE (1 cycle): on the entering edge, gate_a/gate_b take the current vec; settle counter loaded with SETTLE_CYCLES. → SETTLE.
  - SETTLE: counter decrements each cycle. Leaves after exactly SETTLE_CYCLES cycles → SAMPLE.
  - SAMPLE (1 cycle): compare gate_out with expected; a mismatch sets an internal fail flag. If vec<3: vec+1 → DRIVE. Else if sweep<SWEEPS-1: vec=0, sweep+1 → DRIVE. Else → DONE.
  - DONE: busy=0, done=1, pass=~fail; gate_a/gate_b return to 0. start=1 → DRIVE (same clearing as from IDLE; done drops the next cycle).
- busy is 1 in DRIVE, SETTLE and SAMPLE only.
- gate_a/gate_b are held stable through SETTLE and SAMPLE.
- Latency: start seen at edge k → DONE entered at edge k + 4*SWEEPS*(SETTLE_CYCLES+2).
- start while busy is ignored. start held high continuously restarts the run each time DONE is reached.
- Reset asserted mid-run aborts immediately; no partial result is retained.
- gate_out is treated as synchronous to clk, since its inputs are registered here. No synchronizer.

Optional Feature:
GATE_BIST_ERRLOG_EN
- Defined:
  - err_cnt increments on each mismatch in SAMPLE and saturates at 2^ERR_W-1.
  - On the first mismatch of a run, first_fail_vec={gate_a,gate_b} and first_fail_vld=1; later mismatches do not overwrite it.
  - All three are cleared at run start; values persist in DONE.
- Undefined: these ports and their registers are absent; only pass reports the result.

Decomposition:
- Package gate_bist_pkg:
  - state encoding constants (IDLE, DRIVE, SETTLE, SAMPLE, DONE; 3 bits);
  - VEC_W=2, NUM_VEC=4;
  - expected-output function for the AND truth table.
- One sub-module, gate_bist_vecgen: vector counter plus sweep counter, with step/clear inputs, a last flag and vec output. The controller keeps the FSM, settle timer and result logic.

Test Plan:
- Correct AND gate, SETTLE_CYCLES=4, SWEEPS=1, start pulsed at edge 0 → busy=1 after edge 0, done=1 after edge 24, pass=1, err_cnt=0.
- Gate replaced by OR model → pass=0, err_cnt=2, first_fail_vec=01, first_fail_vld=1.
- Output stuck-at-1, SWEEPS=2 → 3 mismatches per sweep, err_cnt=6, pass=0, done after edge 48, first_fail_vec=00.
- Correct gate, extra start pulses at edges 5 and 10 while busy → no effect; done still after edge 24; gate_a/gate_b sequence 00,01,10,11 each held 6 cycles.
- rst asserted during SETTLE of vector 10 → all outputs 0 immediately. After release, start → full 24-cycle run, pass=1.
- ERR_W=2, stuck-at-1, SWEEPS=2 → err_cnt saturates at 3; start in DONE → done low next cycle, err_cnt cleared, new run completes.
